// File: rtl/mpu6050_sample_scheduler.sv
// mpu6050_sample_scheduler: periodic gyro-then-accel read scheduler with atomic frame publish, per-read timeout and overrun tracking
module mpu6050_sample_scheduler #(
   parameter int unsigned PERIOD_CYCLES  = 500000,
   parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        err_clr,
   output logic        gyro_req,
   output logic        accel_req,
   input  logic        gyro_done,
   input  logic        accel_done,
   input  logic [15:0] gyro_x_in,
   input  logic [15:0] gyro_y_in,
   input  logic [15:0] gyro_z_in,
   input  logic [15:0] accel_x_in,
   input  logic [15:0] accel_y_in,
   input  logic [15:0] accel_z_in,
   output logic [15:0] gyro_x,
   output logic [15:0] gyro_y,
   output logic [15:0] gyro_z,
   output logic [15:0] accel_x,
   output logic [15:0] accel_y,
   output logic [15:0] accel_z,
   output logic        sample_valid,
   output logic [15:0] frame_cnt,
   output logic        busy,
   output logic        timeout_err,
   output logic        overrun,
   output logic [7:0]  overrun_cnt
);
   typedef enum logic [2:0] {IDLE, WAIT_TICK, REQ_GYRO, GAP, REQ_ACCEL, PUBLISH} state_t;
   state_t      state, state_nx;
   logic [23:0] per_cnt, to_cnt;
   logic [47:0] g_hold, a_hold;
   logic        tick, to_hit, publish, miss, to_fire;
   assign tick   = enable && (per_cnt == 24'(PERIOD_CYCLES - 1));
   assign to_hit = to_cnt == 24'(TIMEOUT_CYCLES - 1);
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   // next state: a started frame always runs to publish or timeout, enable only matters at frame boundaries
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = enable ? WAIT_TICK : IDLE;
         WAIT_TICK: state_nx = !enable ? IDLE : tick ? REQ_GYRO : WAIT_TICK;
         REQ_GYRO:  state_nx = gyro_done ? GAP : to_hit ? (enable ? WAIT_TICK : IDLE) : REQ_GYRO;
         GAP:       state_nx = REQ_ACCEL;
         REQ_ACCEL: state_nx = accel_done ? PUBLISH : to_hit ? (enable ? WAIT_TICK : IDLE) : REQ_ACCEL;
         PUBLISH:   state_nx = enable ? WAIT_TICK : IDLE;
         default:   state_nx = IDLE;
      endcase
   end
   // state decodes: a done arriving on the last allowed cycle still wins over the timeout
   always_comb begin
      busy    = state inside {REQ_GYRO, GAP, REQ_ACCEL};
      publish = state == PUBLISH;
      miss    = tick && (busy || publish);
      to_fire = to_hit && ((state == REQ_GYRO && !gyro_done) || (state == REQ_ACCEL && !accel_done));
   end
   // period counter, held at zero while disabled so the first tick lands a full period after enable
   always_ff @(posedge clk or posedge rst)
      if (rst) per_cnt <= '0;
      else per_cnt <= (!enable || tick) ? '0 : per_cnt + 24'd1;
   // per-request wait counter, restarts on every entry into a request state
   always_ff @(posedge clk or posedge rst)
      if (rst) to_cnt <= '0;
      else to_cnt <= (state_nx == state && (state == REQ_GYRO || state == REQ_ACCEL)) ? to_cnt + 24'd1 : '0;
   // requests registered from the next state so they track the request states exactly
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         gyro_req  <= 1'b0;
         accel_req <= 1'b0;
      end else begin
         gyro_req  <= state_nx == REQ_GYRO;
         accel_req <= state_nx == REQ_ACCEL;
      end
   // holding registers collect the frame; outputs only move together on publish
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         g_hold                      <= '0;
         a_hold                      <= '0;
         {gyro_x, gyro_y, gyro_z}    <= '0;
         {accel_x, accel_y, accel_z} <= '0;
         frame_cnt                   <= '0;
         sample_valid                <= 1'b0;
      end else begin
         if (state == REQ_GYRO && gyro_done) g_hold <= {gyro_x_in, gyro_y_in, gyro_z_in};
         if (state == REQ_ACCEL && accel_done) a_hold <= {accel_x_in, accel_y_in, accel_z_in};
         if (publish) begin
            {gyro_x, gyro_y, gyro_z}    <= g_hold;
            {accel_x, accel_y, accel_z} <= a_hold;
            frame_cnt                   <= frame_cnt + 16'd1;
         end
         sample_valid <= publish;
      end
   // sticky error flags; a set event in the same cycle as err_clr wins
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         timeout_err <= to_fire || (timeout_err && !err_clr);
         overrun     <= miss || (overrun && !err_clr);
         overrun_cnt <= miss ? (err_clr ? 8'd1 : overrun_cnt + {7'd0, overrun_cnt != 8'hFF}) : (err_clr ? 8'd0 : overrun_cnt);
      end
endmodule

// File: tb/tb_mpu6050_sample_scheduler.sv
// tb_mpu6050_sample_scheduler: randomized directed bench with timing/overrun model derived from frame arithmetic
module tb_mpu6050_sample_scheduler;
   logic        clk = 0, rst = 1;
   logic        enable_a = 0, enable_b = 0, err_clr_a = 0, err_clr_b = 0;
   logic        inj_gdone = 0, inj_adone = 0;
   logic        rd_gdone_a = 0, rd_adone_a = 0, rd_gdone_b = 0, rd_adone_b = 0;
   logic [15:0] gx_in = 0, gy_in = 0, gz_in = 0, ax_in = 0, ay_in = 0, az_in = 0;
   logic        gyro_req_a, accel_req_a, sample_valid_a, busy_a, timeout_err_a, overrun_a;
   logic        gyro_req_b, accel_req_b, sample_valid_b, busy_b, timeout_err_b, overrun_b;
   logic [15:0] gx_a, gy_a, gz_a, ax_a, ay_a, az_a, frame_cnt_a;
   logic [15:0] gx_b, gy_b, gz_b, ax_b, ay_b, az_b, frame_cnt_b;
   logic [7:0]  overrun_cnt_a, overrun_cnt_b;
   logic [95:0] out_a, frame_data = 0, exp_out = 0;
   logic [15:0] exp_fc = 0;
   logic        hold_acc = 0, overlap_seen = 0, g_hit_a, a_hit_a;
   int          cyc = 0, lat_a = 20, ga_cnt = 0, aa_cnt = 0, gb_cnt = 0, ab_cnt = 0, sv_cnt_a = 0;
   int          n_chk = 0, n_fail = 0;
   assign out_a   = {gx_a, gy_a, gz_a, ax_a, ay_a, az_a};
   assign g_hit_a = gyro_req_a && ga_cnt == lat_a;
   assign a_hit_a = accel_req_a && aa_cnt == lat_a && !hold_acc;
   mpu6050_sample_scheduler #(.PERIOD_CYCLES(100), .TIMEOUT_CYCLES(50)) dut_a (
      .clk(clk), .rst(rst), .enable(enable_a), .err_clr(err_clr_a),
      .gyro_req(gyro_req_a), .accel_req(accel_req_a),
      .gyro_done(rd_gdone_a | inj_gdone), .accel_done(rd_adone_a | inj_adone),
      .gyro_x_in(gx_in), .gyro_y_in(gy_in), .gyro_z_in(gz_in),
      .accel_x_in(ax_in), .accel_y_in(ay_in), .accel_z_in(az_in),
      .gyro_x(gx_a), .gyro_y(gy_a), .gyro_z(gz_a), .accel_x(ax_a), .accel_y(ay_a), .accel_z(az_a),
      .sample_valid(sample_valid_a), .frame_cnt(frame_cnt_a), .busy(busy_a),
      .timeout_err(timeout_err_a), .overrun(overrun_a), .overrun_cnt(overrun_cnt_a));
   mpu6050_sample_scheduler #(.PERIOD_CYCLES(30), .TIMEOUT_CYCLES(1000)) dut_b (
      .clk(clk), .rst(rst), .enable(enable_b), .err_clr(err_clr_b),
      .gyro_req(gyro_req_b), .accel_req(accel_req_b),
      .gyro_done(rd_gdone_b), .accel_done(rd_adone_b),
      .gyro_x_in(gx_in), .gyro_y_in(gy_in), .gyro_z_in(gz_in),
      .accel_x_in(ax_in), .accel_y_in(ay_in), .accel_z_in(az_in),
      .gyro_x(gx_b), .gyro_y(gy_b), .gyro_z(gz_b), .accel_x(ax_b), .accel_y(ay_b), .accel_z(az_b),
      .sample_valid(sample_valid_b), .frame_cnt(frame_cnt_b), .busy(busy_b),
      .timeout_err(timeout_err_b), .overrun(overrun_b), .overrun_cnt(overrun_cnt_b));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // reader models: A answers lat_a cycles after its request rises, B always answers after 40
   always @(negedge clk) begin
      ga_cnt     <= gyro_req_a ? ga_cnt + 1 : 0;
      aa_cnt     <= accel_req_a ? aa_cnt + 1 : 0;
      gb_cnt     <= gyro_req_b ? gb_cnt + 1 : 0;
      ab_cnt     <= accel_req_b ? ab_cnt + 1 : 0;
      rd_gdone_a <= g_hit_a;
      rd_adone_a <= a_hit_a;
      rd_gdone_b <= gyro_req_b && gb_cnt == 40;
      rd_adone_b <= accel_req_b && ab_cnt == 40;
      {gx_in, gy_in, gz_in} <= g_hit_a ? frame_data[95:48] : {16'($urandom), 16'($urandom), 16'($urandom)};
      {ax_in, ay_in, az_in} <= a_hit_a ? frame_data[47:0] : {16'($urandom), 16'($urandom), 16'($urandom)};
   end
   // passive monitor
   always @(negedge clk) begin
      if (sample_valid_a) sv_cnt_a <= sv_cnt_a + 1;
      if ((gyro_req_a && accel_req_a) || (gyro_req_b && accel_req_b)) overlap_seen <= 1'b1;
   end
   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic sig(input int w);
      return w == 0 ? gyro_req_a : w == 1 ? accel_req_a : w == 2 ? sample_valid_a : gyro_req_b;
   endfunction
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic step_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask
   task automatic wait_until(input int w, input logic lvl, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sig(w) === lvl) begin
            at = cyc;
            break;
         end
      end
   endtask
   // overruns visible by d cycles after B's first request: miss edges every 30 cycles except each frame start
   function automatic int ovr_model(input int d);
      int m;
      m = d / 30;
      return (m - m / 3) > 255 ? 255 : m - m / 3;
   endfunction
   // B frames: 40+2+40+1 cycles of work, one publish every third period
   function automatic int fc_model(input int d);
      return d < 84 ? 0 : (d - 84) / 90 + 1;
   endfunction
   // one frame on A starting at cycle r with reader latency l
   task automatic frame_a(input int r, input int l, input bit accel_to, input bit drop_en, input logic [95:0] data);
      int t, sv0;
      lat_a = l;
      hold_acc = accel_to;
      frame_data = data;
      wait_until(0, 1, 250, t);
      chk("gyro_req rise", t, r);
      if (drop_en) enable_a = 0;
      wait_until(0, 0, 40, t);
      chk("gyro_req fall", t, r + l + 1);
      wait_until(1, 1, 10, t);
      chk("accel_req rise", t, r + l + 2);
      chk("no partial frame", out_a, exp_out);
      chk("busy in frame", busy_a, 1);
      sv0 = sv_cnt_a;
      if (accel_to) begin
         wait_until(1, 0, 60, t);
         chk("accel timeout drop", t, r + l + 52);
         chk("timeout_err set", timeout_err_a, 1);
         step(3);
         chk("no sample_valid on timeout", sv_cnt_a - sv0, 0);
         chk("outputs hold on timeout", out_a, exp_out);
         chk("frame_cnt hold on timeout", frame_cnt_a, exp_fc);
      end else begin
         wait_until(1, 0, 40, t);
         chk("accel_req fall", t, r + 2 * l + 3);
         wait_until(2, 1, 5, t);
         chk("sample_valid time", t, r + 2 * l + 4);
         exp_out = data;
         exp_fc++;
         chk("published frame", out_a, exp_out);
         chk("frame_cnt", frame_cnt_a, exp_fc);
         step(1);
         chk("sample_valid one cycle", sample_valid_a, 0);
      end
   endtask
   initial begin
      int e, r, rb, t, m;
      step(3);
      chk("reset A data", out_a, 0);
      chk("reset A status", {frame_cnt_a, overrun_cnt_a, gyro_req_a, accel_req_a, sample_valid_a, busy_a, timeout_err_a, overrun_a}, 0);
      chk("reset B status", {frame_cnt_b, overrun_cnt_b, gyro_req_b, accel_req_b, sample_valid_b, busy_b, timeout_err_b, overrun_b}, 0);
      rst = 0;
      step(2);
      enable_a = 1;
      e = cyc;
      r = e + 100;
      frame_a(r, 20, 0, 0, {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666});
      for (int i = 0; i < 3; i++) begin
         r += 100;
         frame_a(r, $urandom_range(5, 30), 0, 0, {$urandom, $urandom, $urandom});
      end
      r += 100;
      frame_a(r, $urandom_range(5, 30), 1, 0, {$urandom, $urandom, $urandom});
      chk("no overrun on A", overrun_a, 0);
      err_clr_a = 1;
      step(1);
      err_clr_a = 0;
      chk("err_clr clears timeout_err", timeout_err_a, 0);
      r += 100;
      frame_a(r, $urandom_range(5, 30), 0, 0, {$urandom, $urandom, $urandom});
      r += 100;
      frame_a(r, $urandom_range(5, 30), 0, 1, {$urandom, $urandom, $urandom});
      chk("idle after disabled frame", busy_a, 0);
      wait_until(0, 1, 250, t);
      chk("no gyro_req after disable", t, -1);
      enable_b = 1;
      rb = cyc + 30;
      wait_until(3, 1, 40, t);
      chk("B gyro_req rise", t, rb);
      step_to(rb + 29);
      chk("B overrun before first miss", overrun_b, 0);
      step_to(rb + 30);
      chk("B overrun on first miss", {overrun_b, overrun_cnt_b}, {1'b1, 8'd1});
      for (int i = 0; i < 4; i++) begin
         step_to(cyc + $urandom_range(100, 2500));
         chk("B overrun_cnt", overrun_cnt_b, ovr_model(cyc - rb));
         chk("B frame_cnt", frame_cnt_b, fc_model(cyc - rb));
      end
      step_to(rb + 30 * 400 + 7);
      chk("B overrun_cnt saturated", overrun_cnt_b, 255);
      m = (cyc - rb) / 30 + 2;
      if (m % 3 == 0) m++;
      step_to(rb + 30 * m - 1);
      err_clr_b = 1;
      step(1);
      err_clr_b = 0;
      chk("B err_clr with miss", {overrun_b, overrun_cnt_b}, {1'b1, 8'd1});
      err_clr_b = 1;
      step(1);
      err_clr_b = 0;
      chk("B err_clr alone", {overrun_b, overrun_cnt_b}, 0);
      enable_b = 0;
      enable_a = 1;
      r = cyc + 100;
      lat_a = 10;
      hold_acc = 0;
      wait_until(0, 1, 150, t);
      chk("A gyro_req before reset", t, r);
      wait_until(1, 1, 30, t);
      chk("A accel_req before reset", t, r + 12);
      #2 rst = 1;
      #1;
      chk("reset drops accel_req", {gyro_req_a, accel_req_a, sample_valid_a}, 0);
      chk("reset clears A data", out_a, 0);
      chk("reset clears A counters", {frame_cnt_a, overrun_cnt_a, timeout_err_a, overrun_a}, 0);
      @(negedge clk);
      rst = 0;
      e = cyc;
      inj_gdone = 1;
      inj_adone = 1;
      step(2);
      inj_gdone = 0;
      inj_adone = 0;
      step(2);
      chk("late done ignored", {frame_cnt_a, sample_valid_a, gyro_req_a, accel_req_a, busy_a}, 0);
      chk("late done no data", out_a, 0);
      wait_until(0, 1, 150, t);
      chk("first tick after reset", t, e + 100);
      chk("requests never overlap", overlap_seen, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
